// File: rtl/ttl_input_timestamper.sv
// Single TTL input channel: synchronizes the pin, detects selected edges and queues
// 128-bit timestamped event records in a first-word-fall-through FIFO.
module ttl_input_timestamper #(
  parameter logic [15:0] SRC_VAL     = 16'h0,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ttl_in,
  input  logic [63:0]                   counter,
  input  logic                          enable,
  input  logic [1:0]                    edge_mode,
  input  logic                          clear,
  output logic [127:0]                  event_data,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [31:0]    seq_q, seq_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           drop_since_q, drop_since_d;
  logic [127:0]   mem_q [FIFO_DEPTH];

  logic           sync_out;
  logic           rise;
  logic           fall;
  logic           evt;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           drop;
  logic [127:0]   record;

  // The synchronizer keeps running through clear so no edge context is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ttl_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;
  assign evt      = enable & ((rise & edge_mode[0]) | (fall & edge_mode[1]));

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign pop   = ~empty & event_ready & ~clear;
  assign push  = evt & ~clear & (~full | pop);
  assign drop  = evt & ~clear & ~push;

  // Back-date the timestamp by the synchronizer depth so it reflects the first sampling cycle.
  assign record = {counter - 64'(SYNC_STAGES), SRC_VAL, seq_q, 14'd0, rise, drop_since_q};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    seq_d        = seq_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    drop_since_d = drop_since_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      seq_d        = '0;
      overflow_d   = 1'b0;
      drop_cnt_d   = '0;
      drop_since_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (evt) seq_d = seq_q + 32'd1;
      if (drop) begin
        overflow_d   = 1'b1;
        drop_since_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else if (push) begin
        drop_since_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      drop_since_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_since_q <= drop_since_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the level counter alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= record;
  end

  assign event_valid = ~empty;
  assign event_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_ttl_input_timestamper.sv
// Directed self-checking bench for ttl_input_timestamper (FIFO_DEPTH=4, SYNC_STAGES=2).
module tb_ttl_input_timestamper;

  localparam int          DEPTH = 4;
  localparam logic [15:0] SRC   = 16'hA5C3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ttl_in = 1'b0;
  logic [63:0]  counter = 64'd0;
  logic         enable = 1'b0;
  logic [1:0]   edge_mode = 2'b00;
  logic         clear = 1'b0;
  logic         event_ready = 1'b0;
  logic [127:0] event_data;
  logic         event_valid;
  logic [2:0]   fifo_level;
  logic         overflow;
  logic [15:0]  drop_count;

  logic         cntLoad = 1'b0;
  logic [63:0]  cntLoadVal = 64'd0;

  int checks = 0;
  int errors = 0;

  ttl_input_timestamper #(
    .SRC_VAL(SRC), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .ttl_in(ttl_in), .counter(counter), .enable(enable),
    .edge_mode(edge_mode), .clear(clear), .event_data(event_data),
    .event_valid(event_valid), .event_ready(event_ready), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // The global timestamp counter advances every clock and can be preloaded.
  always @(posedge clk) counter <= cntLoad ? cntLoadVal : counter + 64'd1;

  function automatic logic [127:0] rec(input logic [63:0] ts, input logic [31:0] seq,
                                       input logic rise, input logic drp);
    return {ts, SRC, seq, 14'd0, rise, drp};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setCounter(input logic [63:0] v);
    cntLoad = 1'b1;
    cntLoadVal = v;
    @(negedge clk);
    cntLoad = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic popOne();
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  // Flip the input, note the sampling-cycle counter, and hold for two clocks.
  task automatic toggle(output logic [63:0] ts, output logic rise);
    ttl_in = ~ttl_in;
    ts = counter;
    rise = ttl_in;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", event_valid); end
    checks++; if (event_data !== 128'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", event_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_drops got %0d want 0", drop_count); end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_rising_only();
    enable = 1'b1;
    edge_mode = 2'b01;
    setCounter(64'd1000);
    step(5);
    ttl_in = 1'b1;
    step(2);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_early_valid got %b want 0", event_valid); end
    step(1);
    checks++; if (event_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_valid got %b want 1", event_valid); end
    checks++; if (event_data !== rec(64'd1005, 32'd0, 1'b1, 1'b0)) begin errors++; $display("[TB] FAIL t1_record got %h want %h", event_data, rec(64'd1005, 32'd0, 1'b1, 1'b0)); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL t1_level got %0d want 1", fifo_level); end
    popOne();
    checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_pop_valid got %b want 0", event_valid); end
    ttl_in = 1'b0;
    step(5);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t1_fall_ignored got %0d want 0", fifo_level); end
  endtask

  task automatic test_both_edges();
    pulseClear();
    edge_mode = 2'b11;
    setCounter(64'd200);
    ttl_in = 1'b1;
    step(3);
    ttl_in = 1'b0;
    step(4);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL t2_level got %0d want 2", fifo_level); end
    checks++; if (event_data !== rec(64'd200, 32'd0, 1'b1, 1'b0)) begin errors++; $display("[TB] FAIL t2_rise got %h want %h", event_data, rec(64'd200, 32'd0, 1'b1, 1'b0)); end
    popOne();
    checks++; if (event_data !== rec(64'd203, 32'd1, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL t2_fall got %h want %h", event_data, rec(64'd203, 32'd1, 1'b0, 1'b0)); end
    popOne();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t2_empty got %0d want 0", fifo_level); end
  endtask

  task automatic test_enable();
    logic [63:0] ts;
    enable = 1'b0;
    ttl_in = 1'b1;
    step(5);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL en_disabled got %0d want 0", fifo_level); end
    enable = 1'b1;
    ttl_in = 1'b0;
    ts = counter;
    step(4);
    checks++; if (event_data !== rec(ts, 32'd2, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL en_record got %h want %h", event_data, rec(ts, 32'd2, 1'b0, 1'b0)); end
    popOne();
  endtask

  task automatic test_overflow();
    logic [63:0] ts [7];
    logic        rs [7];
    pulseClear();
    for (int i = 0; i < 6; i++) toggle(ts[i], rs[i]);
    step(2);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL t3_level got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL t3_overflow got %b want 1", overflow); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("[TB] FAIL t3_drops got %0d want 2", drop_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (event_data !== rec(ts[i], 32'(i), rs[i], 1'b0)) begin errors++; $display("[TB] FAIL t3_drain%0d got %h want %h", i, event_data, rec(ts[i], 32'(i), rs[i], 1'b0)); end
      popOne();
    end
    toggle(ts[6], rs[6]);
    step(2);
    checks++; if (event_data !== rec(ts[6], 32'd6, rs[6], 1'b1)) begin errors++; $display("[TB] FAIL t3_after_drop got %h want %h", event_data, rec(ts[6], 32'd6, rs[6], 1'b1)); end
    popOne();
  endtask

  task automatic test_full_with_pop();
    logic [63:0] ts [5];
    logic        rs [5];
    pulseClear();
    for (int i = 0; i < 4; i++) toggle(ts[i], rs[i]);
    step(2);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL t4_full got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL t4_ovf_cleared got %b want 0", overflow); end
    ttl_in = ~ttl_in;
    ts[4] = counter;
    rs[4] = ttl_in;
    step(2);
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL t4_level got %0d want 4", fifo_level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL t4_drops got %0d want 0", drop_count); end
    checks++; if (event_data !== rec(ts[1], 32'd1, rs[1], 1'b0)) begin errors++; $display("[TB] FAIL t4_head got %h want %h", event_data, rec(ts[1], 32'd1, rs[1], 1'b0)); end
    for (int i = 2; i < 5; i++) begin
      popOne();
      checks++; if (event_data !== rec(ts[i], 32'(i), rs[i], 1'b0)) begin errors++; $display("[TB] FAIL t4_drain%0d got %h want %h", i, event_data, rec(ts[i], 32'(i), rs[i], 1'b0)); end
    end
    popOne();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t4_empty got %0d want 0", fifo_level); end
  endtask

  task automatic test_clear();
    logic [63:0] ts;
    logic        rs;
    for (int i = 0; i < 3; i++) toggle(ts, rs);
    step(2);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL t5_queued got %0d want 3", fifo_level); end
    ttl_in = ~ttl_in;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t5_level got %0d want 0", fifo_level); end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5_valid got %b want 0", event_valid); end
    step(3);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t5_discard got %0d want 0", fifo_level); end
    toggle(ts, rs);
    step(2);
    checks++; if (event_data !== rec(ts, 32'd0, rs, 1'b0)) begin errors++; $display("[TB] FAIL t5_seq_restart got %h want %h", event_data, rec(ts, 32'd0, rs, 1'b0)); end
  endtask

  task automatic test_async_reset();
    logic [63:0] ts;
    logic        rs;
    popOne();
    toggle(ts, rs);
    toggle(ts, rs);
    step(2);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL t6_pre_level got %0d want 2", fifo_level); end
    checks++; if (ttl_in !== 1'b1) begin errors++; $display("[TB] FAIL t6_pin_high got %b want 1", ttl_in); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL t6_valid got %b want 0", event_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL t6_level got %0d want 0", fifo_level); end
    checks++; if (event_data !== 128'd0) begin errors++; $display("[TB] FAIL t6_data got %h want 0", event_data); end
    @(negedge clk);
    reset = 1'b1;
    ts = counter;
    step(3);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL t6_post_level got %0d want 1", fifo_level); end
    checks++; if (event_data !== rec(ts, 32'd0, 1'b1, 1'b0)) begin errors++; $display("[TB] FAIL t6_record got %h want %h", event_data, rec(ts, 32'd0, 1'b1, 1'b0)); end
  endtask

  initial begin
    test_reset();
    test_rising_only();
    test_both_edges();
    test_enable();
    test_overflow();
    test_full_with_pop();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
